// File: rtl/adc_ctrl_if.sv
// adc_ctrl_if
//   Bundles the controller's start/result handshake and the three-wire ADC bus.
//   master : the controller side (drives adc_clk, adc_cs_n, dout, con_ok)
//   slave  : the environment side (drives adc_en and the ADC's serial adc_out)
//   Signals:
//     adc_en   start request
//     adc_out  serial data from the ADC, MSB first
//     adc_clk  serial clock to the ADC
//     adc_cs_n ADC chip select, active-low
//     dout     last converted byte
//     con_ok   one-cycle strobe, dout valid in the same cycle
interface adc_ctrl_if;
   logic       adc_en;
   logic       adc_out;
   logic       adc_clk;
   logic       adc_cs_n;
   logic [7:0] dout;
   logic       con_ok;

   modport master (
      input  adc_en,
      input  adc_out,
      output adc_clk,
      output adc_cs_n,
      output dout,
      output con_ok
   );

   modport slave (
      output adc_en,
      output adc_out,
      input  adc_clk,
      input  adc_cs_n,
      input  dout,
      input  con_ok
   );
endinterface

// File: rtl/adc_ctrl.sv
// adc_ctrl
//   Serial read controller for an 8-bit TLC549-style ADC. A start request
//   lowers chip select, waits one serial-clock period of setup, then produces
//   eight adc_clk pulses and shifts adc_out in MSB first. The byte is presented
//   on dout with a one-cycle con_ok strobe, after which the controller stays
//   busy for CONV_WAIT cycles so the converter can finish its next conversion.
//   Ports:
//     s_clk  system clock, all logic on the rising edge
//     s_rst  synchronous active-high reset
//     bus    adc_ctrl_if.master (adc_en, adc_out in; adc_clk, adc_cs_n, dout, con_ok out)
//   Parameters:
//     CLK_DIV   system clocks per adc_clk period (4..1023)
//     CONV_WAIT busy cycles after each read
module adc_ctrl #(
   parameter int CLK_DIV   = 125,
   parameter int CONV_WAIT = 1000
) (
   input  logic        s_clk,
   input  logic        s_rst,
   adc_ctrl_if.master  bus
);

   localparam int DIV_W  = $clog2(CLK_DIV);
   localparam int WAIT_W = $clog2(CONV_WAIT + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CONV_WAIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      WAIT  = 2'd3
   } state_t;

   state_t             state_reg,    state_next;
   logic [DIV_W-1:0]   div_cnt_reg,  div_cnt_next;
   logic [2:0]         bit_cnt_reg,  bit_cnt_next;
   logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
   logic [7:0]         shreg_reg,    shreg_next;
   logic [7:0]         dout_reg,     dout_next;
   logic               con_ok_reg,   con_ok_next;
   logic               cs_n_reg,     cs_n_next;
   logic               adc_clk_reg,  adc_clk_next;

   // Shift register moved left by one with the serial input entering at bit 0.
   logic [7:0]         shreg_shifted;

   assign shreg_shifted[0] = bus.adc_out;

   generate
      for (genvar gi = 1; gi < 8; gi++) begin : g_shift
         assign shreg_shifted[gi] = shreg_reg[gi-1];
      end
   endgenerate

   always_comb begin
      state_next    = state_reg;
      div_cnt_next  = div_cnt_reg;
      bit_cnt_next  = bit_cnt_reg;
      wait_cnt_next = wait_cnt_reg;
      shreg_next    = shreg_reg;
      dout_next     = dout_reg;
      con_ok_next   = 1'b0;
      adc_clk_next  = 1'b0;

      unique case (state_reg)
         IDLE: begin
            if (bus.adc_en) begin
               state_next   = SETUP;
               div_cnt_next = '0;
            end
         end

         SETUP: begin
            if (div_cnt_reg == DIV_LAST) begin
               state_next   = SHIFT;
               div_cnt_next = '0;
               bit_cnt_next = '0;
            end else begin
               div_cnt_next = div_cnt_reg + DIV_W'(1);
            end
         end

         SHIFT: begin
            // The data sample is taken on the edge just before adc_clk rises,
            // so the bit the ADC put out after the previous fall is settled.
            if (div_cnt_reg == DIV_HALF) begin
               shreg_next = shreg_shifted;
            end
            // Look-ahead: the registered clock is high in the cycles where
            // div_cnt is HALF+1 .. LAST, and never spills into the next bit.
            adc_clk_next = (div_cnt_reg >= DIV_HALF) && (div_cnt_reg != DIV_LAST);

            if (div_cnt_reg == DIV_LAST) begin
               div_cnt_next = '0;
               bit_cnt_next = bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == 3'd7) begin
                  state_next    = WAIT;
                  wait_cnt_next = '0;
                  dout_next     = shreg_reg;
                  con_ok_next   = 1'b1;
               end
            end else begin
               div_cnt_next = div_cnt_reg + DIV_W'(1);
            end
         end

         WAIT: begin
            if (wait_cnt_reg == WAIT_LAST) begin
               state_next    = IDLE;
               wait_cnt_next = '0;
            end else begin
               wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
            end
         end

         default: state_next = IDLE;
      endcase

      // Chip select follows the state being entered so it is registered.
      cs_n_next = !((state_next == SETUP) || (state_next == SHIFT));
   end

   always_ff @(posedge s_clk) begin
      if (s_rst) begin
         state_reg    <= IDLE;
         div_cnt_reg  <= '0;
         bit_cnt_reg  <= '0;
         wait_cnt_reg <= '0;
         shreg_reg    <= '0;
         dout_reg     <= '0;
         con_ok_reg   <= 1'b0;
         cs_n_reg     <= 1'b1;
         adc_clk_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         div_cnt_reg  <= div_cnt_next;
         bit_cnt_reg  <= bit_cnt_next;
         wait_cnt_reg <= wait_cnt_next;
         shreg_reg    <= shreg_next;
         dout_reg     <= dout_next;
         con_ok_reg   <= con_ok_next;
         cs_n_reg     <= cs_n_next;
         adc_clk_reg  <= adc_clk_next;
      end
   end

   assign bus.adc_clk  = adc_clk_reg;
   assign bus.adc_cs_n = cs_n_reg;
   assign bus.dout     = dout_reg;
   assign bus.con_ok   = con_ok_reg;

endmodule

// File: tb/tb_adc_ctrl.sv
// tb_adc_ctrl
//   Directed bench for adc_ctrl with default parameters (CLK_DIV=125,
//   CONV_WAIT=1000). A serial ADC model shifts a byte out on adc_clk falls;
//   a negedge monitor time-stamps chip select, clock rises and con_ok.
module tb_adc_ctrl;
   logic s_clk = 1'b0;
   logic s_rst = 1'b1;

   adc_ctrl_if bus ();

   adc_ctrl #(.CLK_DIV(125), .CONV_WAIT(1000)) dut (
      .s_clk (s_clk),
      .s_rst (s_rst),
      .bus   (bus)
   );

   always #10 s_clk = ~s_clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input int observed, input int expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  tag, observed, observed, expected, expected);
      end else begin
         $display("ok   %s: %0d", tag, observed);
      end
   endtask

   // ---------------- monitor ----------------
   int ncyc = 0, ok_cnt = 0, last_ok_t = 0;
   int rise_cnt = 0, rd_rises = 0, first_rise_t = 0, rise_prev = 0, rise_last = 0;
   int cs_low_cnt = 0;
   logic [7:0] ok_dout = 8'h00;
   logic prev_clk_m = 1'b0, prev_cs_m = 1'b1;

   always @(negedge s_clk) begin
      ncyc++;
      if (!bus.adc_cs_n) begin
         cs_low_cnt++;
         if (prev_cs_m) rd_rises = 0;
      end
      if (bus.adc_clk && !prev_clk_m) begin
         rise_cnt++;
         rd_rises++;
         rise_prev = rise_last;
         rise_last = ncyc;
         if (rd_rises == 1) first_rise_t = ncyc;
      end
      if (bus.con_ok) begin
         ok_cnt++;
         last_ok_t = ncyc;
         ok_dout   = bus.dout;
      end
      prev_clk_m = bus.adc_clk;
      prev_cs_m  = bus.adc_cs_n;
   end

   // ---------------- ADC serial model ----------------
   logic [7:0] pat = 8'h00;
   int   bidx = 0;
   logic prev_clk_d = 1'b0;

   always @(negedge s_clk) begin
      if (bus.adc_cs_n) bidx = 0;
      else if (prev_clk_d && !bus.adc_clk) bidx++;
      bus.adc_out = (bidx < 8) ? pat[7-bidx] : 1'b0;
      prev_clk_d  = bus.adc_clk;
   end

   // ---------------- helpers ----------------
   task automatic wait_ok(input int ok0);
      for (int i = 0; i < 3000; i++) begin
         if (ok_cnt != ok0) break;
         @(negedge s_clk); #1;
      end
      if (ok_cnt == ok0) check("ok_timeout", ok_cnt - ok0, 1);
   endtask

   task automatic start_read(input logic [7:0] p, output int t, output int ok0,
                             output int r0, output int l0);
      @(negedge s_clk);
      pat        = p;
      bus.adc_en = 1'b1;
      @(posedge s_clk); #1;
      t   = ncyc;
      ok0 = ok_cnt;
      r0  = rise_cnt;
      l0  = cs_low_cnt;
      @(negedge s_clk);
      bus.adc_en = 1'b0;
   endtask

   task automatic do_read(input logic [7:0] p, input string nm);
      int t, ok0, r0, l0;
      start_read(p, t, ok0, r0, l0);
      wait_ok(ok0);
      check({nm, "_ok_latency"}, last_ok_t - t, 1126);
      check({nm, "_dout"}, int'(ok_dout), int'(p));
      check({nm, "_first_rise"}, first_rise_t - t, 189);
      check({nm, "_clk_period"}, rise_last - rise_prev, 125);
      repeat (20) @(negedge s_clk);
      #1;
      check({nm, "_pulses"}, rise_cnt - r0, 8);
      check({nm, "_cs_low"}, cs_low_cnt - l0, 1125);
      check({nm, "_ok_count"}, ok_cnt - ok0, 1);
      repeat (1000) @(negedge s_clk);
      #1;
      check({nm, "_dout_hold"}, int'(bus.dout), int'(p));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t, ok0, r0, l0, t1, t2;
      bus.adc_en = 1'b1;            // reset must win over a start request
      s_rst      = 1'b1;
      repeat (3) @(posedge s_clk);
      @(negedge s_clk);
      s_rst      = 1'b0;
      bus.adc_en = 1'b0;
      #1;
      check("rst_cs_n",    int'(bus.adc_cs_n), 1);
      check("rst_adc_clk", int'(bus.adc_clk),  0);
      check("rst_dout",    int'(bus.dout),     0);
      check("rst_con_ok",  int'(bus.con_ok),   0);
      r0 = rise_cnt; l0 = cs_low_cnt;
      repeat (100) @(negedge s_clk);
      #1;
      check("idle_no_clk", rise_cnt - r0, 0);
      check("idle_no_cs",  cs_low_cnt - l0, 0);

      do_read(8'hFF, "const");
      do_read(8'hA5, "pattern");

      // Busy rejection: start requests in SHIFT and in WAIT are ignored.
      start_read(8'h81, t, ok0, r0, l0);
      repeat (400) @(negedge s_clk);
      bus.adc_en = 1'b1;
      @(negedge s_clk);
      bus.adc_en = 1'b0;
      wait_ok(ok0);
      repeat (500) @(negedge s_clk);
      bus.adc_en = 1'b1;
      @(negedge s_clk);
      bus.adc_en = 1'b0;
      repeat (700) @(negedge s_clk);
      #1;
      check("busy_ok_count", ok_cnt - ok0, 1);
      check("busy_cs_low",   cs_low_cnt - l0, 1125);
      check("busy_pulses",   rise_cnt - r0, 8);
      check("busy_dout",     int'(ok_dout), 8'h81);
      do_read(8'h3C, "second");

      // Continuous start request: back-to-back reads.
      @(negedge s_clk);
      pat        = 8'h5A;
      bus.adc_en = 1'b1;
      ok0        = ok_cnt;
      wait_ok(ok0);
      t1 = last_ok_t;
      wait_ok(ok0 + 1);
      t2 = last_ok_t;
      @(negedge s_clk);
      bus.adc_en = 1'b0;
      check("cont_period", t2 - t1, 2126);
      check("cont_dout",   int'(ok_dout), 8'h5A);
      repeat (1200) @(negedge s_clk);

      // Reset after the 4th adc_clk pulse of a read.
      start_read(8'hC3, t, ok0, r0, l0);
      for (int i = 0; i < 1200; i++) begin
         @(negedge s_clk); #1;
         if (rd_rises == 4 && !bus.adc_clk) break;
      end
      check("mid_rises_before_rst", rd_rises, 4);
      s_rst = 1'b1;
      @(posedge s_clk); #1;
      check("mid_rst_cs_n",    int'(bus.adc_cs_n), 1);
      check("mid_rst_adc_clk", int'(bus.adc_clk),  0);
      check("mid_rst_dout",    int'(bus.dout),     0);
      check("mid_rst_con_ok",  int'(bus.con_ok),   0);
      @(negedge s_clk);
      s_rst = 1'b0;
      r0 = rise_cnt;
      repeat (1300) @(negedge s_clk);
      #1;
      check("mid_rst_no_ok",   ok_cnt - ok0, 0);
      check("mid_rst_no_clk",  rise_cnt - r0, 0);
      check("mid_rst_dout_0",  int'(bus.dout), 0);
      do_read(8'h96, "after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
